// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared pipeline-control types and constants
package cpu_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrlState_t;

  // r0 is hardwired to zero, so a write to it can never feed a consumer.
  function automatic logic srcMatch(
    input logic [REG_W-1:0] dest,
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rt,
    input logic             usesRt
  );
    return (dest != REG_ZERO) && ((rs == dest) || (usesRt && (rt == dest)));
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational hazard conditions folded into one stall bit
module hazard_detect
  import cpu_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] IDRegRs,
  input  logic [REG_W-1:0] IDRegRt,
  input  logic             ID_UsesRt,
  input  logic             ID_Branch,
  input  logic             ID_JumpReg,
  input  logic             EX_MemRead,
  input  logic             EX_RegWrite,
  input  logic [REG_W-1:0] EXRegRd,
  input  logic             MEM_MemRead,
  input  logic [REG_W-1:0] MEMRegRd,
  output logic             stall
);

  logic exMatch;
  logic memMatch;
  logic idConsumes;
  logic loadUse;
  logic branchEx;
  logic branchMem;

  assign exMatch    = srcMatch(EXRegRd, IDRegRs, IDRegRt, ID_UsesRt);
  assign memMatch   = srcMatch(MEMRegRd, IDRegRs, IDRegRt, ID_UsesRt);

  // Branch compares and JR targets are consumed in ID, before EX forwarding can help.
  assign idConsumes = ID_Branch | ID_JumpReg;

  assign loadUse    = EX_MemRead & exMatch;
  assign branchEx   = idConsumes & EX_RegWrite & exMatch;
  assign branchMem  = idConsumes & MEM_MemRead & memMatch;

  assign stall      = loadUse | branchEx | branchMem;

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - stall/flush control, debug halt/drain FSM and stall counter
module hazard_stall_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] IDRegRs,
  input  logic [REG_W-1:0] IDRegRt,
  input  logic             ID_UsesRt,
  input  logic             ID_Branch,
  input  logic             ID_JumpReg,
  input  logic             ID_Jump,
  input  logic             BranchTaken,
  input  logic             EX_MemRead,
  input  logic             EX_RegWrite,
  input  logic [REG_W-1:0] EXRegRd,
  input  logic             MEM_MemRead,
  input  logic [REG_W-1:0] MEMRegRd,
  input  logic             HaltReq,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXBubble,
  output logic             HaltAck,
  output logic [CNT_W-1:0] StallCount
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  ctrlState_t         state;
  ctrlState_t         nextState;
  logic               hazard;
  logic               stallActive;
  logic               ctrlInId;
  logic [DRAIN_W-1:0] drainCnt;
  logic               haltAckQ;
  logic [CNT_W-1:0]   stallCnt;

  hazard_detect uDetect (
    .IDRegRs    (IDRegRs),
    .IDRegRt    (IDRegRt),
    .ID_UsesRt  (ID_UsesRt),
    .ID_Branch  (ID_Branch),
    .ID_JumpReg (ID_JumpReg),
    .EX_MemRead (EX_MemRead),
    .EX_RegWrite(EX_RegWrite),
    .EXRegRd    (EXRegRd),
    .MEM_MemRead(MEM_MemRead),
    .MEMRegRd   (MEMRegRd),
    .stall      (hazard)
  );

  // A frozen pipeline has nothing moving, so hazards are neither stalled nor counted.
  assign stallActive = hazard && (state != HALTED);
  assign ctrlInId    = ID_Branch | ID_JumpReg | ID_Jump;

  always_comb begin
    nextState  = state;
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXBubble = 1'b0;

    unique case (state)
      RUN: begin
        if (stallActive) begin
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          IDEXBubble = 1'b1;
        end else begin
          IFIDFlush = BranchTaken;
          if (HaltReq && !ctrlInId) begin
            nextState = DRAIN;
          end
        end
      end

      DRAIN: begin
        // PC is held and NOPs are fed into IF/ID while older instructions retire.
        PCWrite = 1'b0;
        if (stallActive) begin
          IFIDWrite  = 1'b0;
          IDEXBubble = 1'b1;
        end else begin
          IFIDFlush = 1'b1;
        end
        if (!HaltReq) begin
          nextState = RUN;
        end else if (!stallActive && (drainCnt == DRAIN_LAST)) begin
          nextState = HALTED;
        end
      end

      HALTED: begin
        PCWrite    = 1'b0;
        IFIDWrite  = 1'b0;
        IDEXBubble = 1'b1;
        if (!HaltReq) begin
          nextState = RUN;
        end
      end

      default: begin
        nextState = RUN;
      end
    endcase

    if (reset) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= nextState;
    end
  end

  // Only non-stalled cycles retire an instruction, so only those count toward the drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drainCnt <= '0;
    end else if (state != DRAIN) begin
      drainCnt <= '0;
    end else if (!stallActive) begin
      drainCnt <= drainCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      haltAckQ <= 1'b0;
    end else begin
      haltAckQ <= (nextState == HALTED);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt <= '0;
    end else if (stallActive) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end

  assign HaltAck    = haltAckQ;
  assign StallCount = stallCnt;

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Pipeline control counterpart to the EX-stage forwarding logic. It covers the cases forwarding cannot resolve: load-use, and branch/JR operands needed in ID.
- Drives PC/IF-ID write enables, the ID/EX bubble and the IF/ID flush.
- Owns a halt/drain handshake with the debug unit and a stall-cycle counter.
- Sits beside the 5-stage pipeline registers; one instance per core.

Parameters:
- CNT_W, 32, width of StallCount (wraps modulo 2^CNT_W).
- DRAIN_CYCLES, 4, non-stalled cycles needed to retire ID..WB before halt is acknowledged.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high.
- IDRegRs  in  5  rs field of the instruction in ID.
- IDRegRt  in  5  rt field of the instruction in ID.
- ID_UsesRt  in  1  ID instruction reads rt as a source.
- ID_Branch  in  1  ID holds BEQ/BNE (compare done in ID).
- ID_JumpReg  in  1  ID holds JR/JALR (reads rs in ID).
- ID_Jump  in  1  ID holds J/JAL.
- BranchTaken  in  1  ID-stage branch/jump redirect this cycle.
- EX_MemRead  in  1  load in EX.
- EX_RegWrite  in  1  EX instruction writes a register.
- EXRegRd  in  5  destination of EX instruction (post RegDst mux).
- MEM_MemRead  in  1  load in MEM.
- MEMRegRd  in  5  destination of MEM instruction.
- HaltReq  in  1  debug halt request, level.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register enable.
- IFIDFlush  out  1  load NOP into IF/ID at next edge.
- IDEXBubble  out  1  zero control bits entering ID/EX.
- HaltAck  out  1  pipeline empty and frozen.
- StallCount  out  CNT_W  count of hazard-stall cycles.

Behaviour:
- Clock and reset: single clock clk; reset asynchronous, active-high.
- While reset is high: state=RUN, counters=0; PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXBubble=1, HaltAck=0, StallCount=0.
- Register r0 never causes a hazard: any match against a destination of 0 is ignored.
- srcRs/srcRt matching: a source matches a destination if rs equals it, or if ID_UsesRt=1 and rt equals it.
- Hazard (combinational, same cycle) when any of:
  - (a) load-use: EX_MemRead and EXRegRd matches a source.
  - (b) ID_Branch or ID_JumpReg, and EX_RegWrite with EXRegRd matching a source.
  - (c) ID_Branch or ID_JumpReg, and MEM_MemRead with MEMRegRd matching a source.
- Resulting stall counts: load→branch costs 2 cycles (a/b, then c); ALU→branch costs 1; load→ALU use costs 1.
- Stall outputs: PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=0. BranchTaken is ignored while stalling.
- No stall and BranchTaken=1: IFIDFlush=1, PCWrite=1, IFIDWrite=1.
- FSM states RUN, DRAIN, HALTED:
  - RUN: normal operation. Go to DRAIN when HaltReq=1 and no stall and ID_Branch, ID_JumpReg and ID_Jump are all 0 (a control instruction in ID is allowed to resolve first).
  - DRAIN:
    - PCWrite=0, IFIDFlush=1, IFIDWrite=1.
    - Hazard stalls still apply with priority (IFIDWrite=0, IFIDFlush=0).
    - Drain counter loads 0 on entry and increments only on non-stall cycles.
    - At DRAIN_CYCLES-1 go to HALTED.
    - HaltReq dropping during DRAIN returns to RUN next cycle. The instruction at PC is refetched (PC was held).
  - HALTED:
    - HaltAck=1 (registered, asserted the cycle the state becomes HALTED).
    - PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=0.
    - HaltReq=0 → RUN next cycle; HaltAck=0 in that RUN cycle.
- StallCount: increments on every cycle in which a hazard stall is asserted (RUN or DRAIN); wraps.
- Reset mid-DRAIN or mid-HALTED: immediate return to reset values; no pending stall survives.

Decomposition:
- Shared package cpu_ctrl_pkg: state encoding (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2), register-index width 5, constant REG_ZERO=5'd0.
- Sub-module hazard_detect: purely combinational conditions a/b/c → single stall bit.
- The top level holds the FSM and counters.

Test Plan:
- LW $2 in EX (EX_MemRead=1, EXRegRd=2), ID rs=2 → exactly 1 cycle of PCWrite=0, IFIDWrite=0, IDEXBubble=1; StallCount 0→1.
- LW $3 in EX, BEQ rs=3 in ID → 2 stall cycles (EX match, then MEM_MemRead match); BranchTaken=1 during stalls gives IFIDFlush=0; flush only in the third cycle.
- ADD to $0 in EX, ID rs=0 with ID_Branch=1 → no stall; StallCount unchanged.
- HaltReq=1 with clear pipeline → DRAIN 4 cycles (PCWrite=0, IFIDFlush=1), then HaltAck=1. Drop HaltReq → RUN, HaltAck=0, PCWrite=1 next cycle.
- HaltReq=1 while ID_Jump=1 → stays RUN that cycle. Load-use stall inside DRAIN extends the drain to 5 cycles.
- Assert reset in HALTED and in DRAIN → outputs immediately at reset values, StallCount=0, FSM in RUN after release.
